// File: rtl/pkt_pkg.sv
`default_nettype none
// ============================================================================
// Package   : pkt_pkg
// Purpose   : Packet field widths, packet struct and default lane count, shared
//             with the downstream vector aggregation stage.
// Revision  : 1.0 - initial release
// ============================================================================
package pkt_pkg;

  localparam int HDR_W         = 16;
  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 32;
  localparam int DEFAULT_LANES = 3;

  typedef struct packed {
    logic [HDR_W-1:0]  header;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

endpackage
`default_nettype wire

// File: rtl/vec_out_slot.sv
`default_nettype none
// ============================================================================
// Module    : vec_out_slot
// Purpose   : LANES x packet + mask output holding register with valid/ready;
//             lanes not covered by the mask are held at zero.
// Revision  : 1.0 - initial release
// ============================================================================
module vec_out_slot
  import pkt_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LANES-1:0] i_mask,
  input  pkt_t [LANES-1:0] i_lanes,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [LANES-1:0] o_mask,
  output pkt_t [LANES-1:0] o_lanes,
  output logic             o_slot_free
);

  logic             valid_q, valid_d;
  logic [LANES-1:0] mask_q, mask_d;
  pkt_t [LANES-1:0] lanes_q, lanes_d;
  logic             w_clear;

  assign o_slot_free = !valid_q || i_ready;
  assign w_clear     = valid_q && i_ready;

  always_comb begin
    valid_d = valid_q;
    mask_d  = mask_q;
    lanes_d = lanes_q;
    // A load may coincide with the current vector leaving; the load wins.
    if (i_load) begin
      valid_d = 1'b1;
      mask_d  = i_mask;
      for (int i = 0; i < LANES; i++) begin
        lanes_d[i] = i_mask[i] ? i_lanes[i] : '0;
      end
    end else if (w_clear) begin
      valid_d = 1'b0;
      mask_d  = '0;
      lanes_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      mask_q  <= '0;
      lanes_q <= '0;
    end else begin
      valid_q <= valid_d;
      mask_q  <= mask_d;
      lanes_q <= lanes_d;
    end
  end

  assign o_valid = valid_q;
  assign o_mask  = mask_q;
  assign o_lanes = lanes_q;

endmodule
`default_nettype wire

// File: rtl/vec_agg_packer.sv
`default_nettype none
// ============================================================================
// Module    : vec_agg_packer
// Purpose   : Packs a serial valid/ready packet stream into LANES-wide vectors,
//             with flush of partial vectors and a registered output slot.
// Revision  : 1.0 - initial release
// ============================================================================
module vec_agg_packer
  import pkt_pkg::pkt_t;
  import pkt_pkg::DEFAULT_LANES;
#(
  parameter int LANES  = DEFAULT_LANES,
  parameter int HDR_W  = pkt_pkg::HDR_W,
  parameter int ADDR_W = pkt_pkg::ADDR_W,
  parameter int DATA_W = pkt_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [HDR_W-1:0]  io_in_bits_header,
  input  logic [ADDR_W-1:0] io_in_bits_addr,
  input  logic [DATA_W-1:0] io_in_bits_data,
  input  logic              io_flush,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [LANES-1:0]  io_out_mask,
  output logic [HDR_W-1:0]  io_out_tx_header_0,
  output logic [ADDR_W-1:0] io_out_tx_addr_0,
  output logic [DATA_W-1:0] io_out_tx_data_0,
  output logic [HDR_W-1:0]  io_out_tx_header_1,
  output logic [ADDR_W-1:0] io_out_tx_addr_1,
  output logic [DATA_W-1:0] io_out_tx_data_1,
  output logic [HDR_W-1:0]  io_out_tx_header_2,
  output logic [ADDR_W-1:0] io_out_tx_addr_2,
  output logic [DATA_W-1:0] io_out_tx_data_2,
  output logic [15:0]       io_vecCount
);

  // cnt must also represent LANES: a full vector frozen while pending.
  localparam int              CNT_W  = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LANES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  pkt_t [LANES-1:0] buf_q, buf_d;
  logic [15:0]      vec_count_q, vec_count_d;

  pkt_t             w_in_pkt;
  logic             w_in_fire, w_close, w_load, w_slot_free, w_out_valid;
  logic [CNT_W-1:0] w_fill;
  logic [LANES-1:0] w_vec_mask, w_slot_mask;
  pkt_t [LANES-1:0] w_vec_lanes, w_slot_lanes;
  pkt_t             w_port_lane [3];

  assign w_in_pkt    = '{header: io_in_bits_header, addr: io_in_bits_addr, data: io_in_bits_data};
  assign io_in_ready = !reset && !pending_q;
  assign w_in_fire   = io_in_valid && io_in_ready;

  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    w_close     = 1'b0;
    w_load      = 1'b0;
    w_vec_lanes = buf_q;
    w_fill      = cnt_q;
    w_vec_mask  = '0;
    if (w_in_fire) begin
      buf_d[cnt_q]       = w_in_pkt;
      w_vec_lanes[cnt_q] = w_in_pkt;
      w_fill             = cnt_q + CNT_W'(1);
      cnt_d              = cnt_q + CNT_W'(1);
    end
    if (pending_q) begin
      w_load = w_slot_free;
    end else begin
      w_close = (w_in_fire && cnt_q == C_LAST) ||
                (io_flush && (cnt_q != '0 || w_in_fire));
    end
    if (w_close) begin
      if (w_slot_free) w_load = 1'b1;
      else             pending_d = 1'b1;
    end
    if (w_load) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end
    for (int i = 0; i < LANES; i++) begin
      w_vec_mask[i] = CNT_W'(i) < w_fill;
    end
  end

  always_comb begin
    vec_count_d = vec_count_q;
    if (w_out_valid && io_out_ready) vec_count_d = vec_count_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      buf_q       <= '0;
      vec_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      buf_q       <= buf_d;
      vec_count_q <= vec_count_d;
    end
  end

  vec_out_slot #(
    .LANES (LANES)
  ) u_slot (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_load),
    .i_mask      (w_vec_mask),
    .i_lanes     (w_vec_lanes),
    .i_ready     (io_out_ready),
    .o_valid     (w_out_valid),
    .o_mask      (w_slot_mask),
    .o_lanes     (w_slot_lanes),
    .o_slot_free (w_slot_free)
  );

  for (genvar g = 0; g < 3; g++) begin : g_lane
    if (g < LANES) begin : g_used
      assign w_port_lane[g] = w_slot_lanes[g];
    end else begin : g_unused
      assign w_port_lane[g] = '0;
    end
  end

  assign io_out_valid       = w_out_valid;
  assign io_out_mask        = w_slot_mask;
  assign io_vecCount        = vec_count_q;
  assign io_out_tx_header_0 = w_port_lane[0].header;
  assign io_out_tx_addr_0   = w_port_lane[0].addr;
  assign io_out_tx_data_0   = w_port_lane[0].data;
  assign io_out_tx_header_1 = w_port_lane[1].header;
  assign io_out_tx_addr_1   = w_port_lane[1].addr;
  assign io_out_tx_data_1   = w_port_lane[1].data;
  assign io_out_tx_header_2 = w_port_lane[2].header;
  assign io_out_tx_addr_2   = w_port_lane[2].addr;
  assign io_out_tx_data_2   = w_port_lane[2].data;

endmodule
`default_nettype wire

// File: tb/tb_vec_agg_packer.sv
`default_nettype none
// ============================================================================
// Module    : tb_vec_agg_packer
// Purpose   : Directed stimulus for vec_agg_packer, checked every cycle against
//             a queue-based packing model plus hand-computed expectations.
// Revision  : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vec_agg_packer;
  import pkt_pkg::*;

  localparam int L = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_in_valid = 1'b0;
  logic        io_flush = 1'b0;
  logic        io_out_ready = 1'b1;
  logic [15:0] in_hdr = '0;
  logic [15:0] in_addr = '0;
  logic [31:0] in_data = '0;

  logic        io_in_ready, io_out_valid;
  logic [2:0]  io_out_mask;
  logic [15:0] h0, h1, h2, a0, a1, a2, io_vecCount;
  logic [31:0] d0, d1, d2;

  vec_agg_packer dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_bits_header  (in_hdr),
    .io_in_bits_addr    (in_addr),
    .io_in_bits_data    (in_data),
    .io_flush           (io_flush),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_mask        (io_out_mask),
    .io_out_tx_header_0 (h0),
    .io_out_tx_addr_0   (a0),
    .io_out_tx_data_0   (d0),
    .io_out_tx_header_1 (h1),
    .io_out_tx_addr_1   (a1),
    .io_out_tx_data_1   (d1),
    .io_out_tx_header_2 (h2),
    .io_out_tx_addr_2   (a2),
    .io_out_tx_data_2   (d2),
    .io_vecCount        (io_vecCount)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk(input int d);
    pkt_t p;
    p.header = 16'hA000 | 16'(d);
    p.addr   = 16'h5000 + 16'(d);
    p.data   = 32'(d);
    return p;
  endfunction

  // Model: packets accepted into the open group; a group is handed to the
  // output when it is full or flushed, or parked as pending if the slot is busy.
  pkt_t        grp[$];
  bit          m_pend = 1'b0;
  bit          m_ov = 1'b0;
  logic [2:0]  m_mask = '0;
  pkt_t        m_lane [L] = '{default: '0};
  logic [15:0] m_vc = '0;
  bit          fire, sfree, ofire, ship;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      grp.delete();
      m_pend = 1'b0;
      m_ov   = 1'b0;
      m_mask = '0;
      for (int i = 0; i < L; i++) m_lane[i] = '0;
      m_vc   = '0;
    end else begin
      fire  = io_in_valid && !m_pend;
      sfree = !m_ov || io_out_ready;
      ofire = m_ov && io_out_ready;
      if (ofire) begin
        m_vc++;
        m_ov   = 1'b0;
        m_mask = '0;
        for (int i = 0; i < L; i++) m_lane[i] = '0;
      end
      ship = m_pend;
      if (!m_pend) begin
        if (fire) grp.push_back({in_hdr, in_addr, in_data});
        ship = (fire && grp.size() == L) || (io_flush && grp.size() > 0);
      end
      if (ship) begin
        if (sfree) begin
          m_ov = 1'b1;
          for (int i = 0; i < L; i++) begin
            m_mask[i] = (i < grp.size());
            m_lane[i] = (i < grp.size()) ? grp[i] : '0;
          end
          grp.delete();
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("in_ready",  64'(io_in_ready),  64'(!reset && !m_pend));
    chk("out_valid", 64'(io_out_valid), 64'(m_ov));
    chk("out_mask",  64'(io_out_mask),  64'(m_mask));
    chk("lane0",     {h0, a0, d0},      m_lane[0]);
    chk("lane1",     {h1, a1, d1},      m_lane[1]);
    chk("lane2",     {h2, a2, d2},      m_lane[2]);
    chk("vecCount",  64'(io_vecCount),  64'(m_vc));
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input int d, input bit f);
    step();
    io_in_valid = 1'b1;
    {in_hdr, in_addr, in_data} = mk(d);
    io_flush = f;
  endtask

  task automatic idle(input bit f);
    step();
    io_in_valid = 1'b0;
    io_flush = f;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  int n;

  initial begin
    // Reset in the middle of a fill with a held vector in the output slot.
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    io_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(32'h30 + i, 1'b0);
    step();
    io_in_valid = 1'b0;
    reset = 1'b1;
    at_neg();
    chk("rst_valid", 64'(io_out_valid), 64'd0);
    chk("rst_mask",  64'(io_out_mask),  64'd0);
    chk("rst_data0", 64'(d0),           64'd0);
    chk("rst_ready", 64'(io_in_ready),  64'd0);
    step();
    reset = 1'b0;
    io_out_ready = 1'b1;
    at_neg();
    chk("rel_ready", 64'(io_in_ready), 64'd1);

    // Six back-to-back packets form two full vectors.
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    at_neg();
    chk("v1_mask",  64'(io_out_mask), 64'h7);
    chk("v1_data",  {d0, d1, d2},     {32'd1, 32'd2, 32'd3});
    chk("v1_hdr0",  64'(h0),          64'hA001);
    chk("v1_ready", 64'(io_in_ready), 64'd1);
    send(5, 1'b0);
    send(6, 1'b0);
    idle(1'b0);
    at_neg();
    chk("v2_data", {d0, d1, d2}, {32'd4, 32'd5, 32'd6});
    idle(1'b0);
    at_neg();
    chk("v2_count", 64'(io_vecCount), 64'd2);

    // Flush after two packets, then a flushed single packet lands in lane 0.
    send(7, 1'b0);
    send(8, 1'b0);
    idle(1'b1);
    idle(1'b0);
    at_neg();
    chk("fl_mask", 64'(io_out_mask), 64'h3);
    chk("fl_data", {d0, d1, d2},     {32'd7, 32'd8, 32'd0});
    send(9, 1'b1);
    idle(1'b0);
    at_neg();
    chk("fl0_mask",  64'(io_out_mask), 64'h1);
    chk("fl0_data0", 64'(d0),          64'd9);

    // Flush coinciding with an accepted packet at cnt=1; idle flush is a no-op.
    send(11, 1'b0);
    send(12, 1'b1);
    idle(1'b0);
    at_neg();
    chk("ff_mask", 64'(io_out_mask), 64'h3);
    chk("ff_data", {d0, d1, d2},     {32'd11, 32'd12, 32'd0});
    idle(1'b1);
    idle(1'b0);
    at_neg();
    chk("idle_flush_valid", 64'(io_out_valid), 64'd0);
    chk("idle_flush_count", 64'(io_vecCount),  64'd5);

    // Back-pressure: first vector held, second vector pending.
    io_out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(32'h20 + i, 1'b0);
    idle(1'b0);
    at_neg();
    chk("bp_ready", 64'(io_in_ready), 64'd0);
    chk("bp_data0", 64'(d0),          64'h21);
    idle(1'b0);
    at_neg();
    chk("bp_hold",  {d0, d1, d2},     {32'h21, 32'h22, 32'h23});
    chk("bp_ready2", 64'(io_in_ready), 64'd0);
    step();
    io_out_ready = 1'b1;
    at_neg();
    chk("bp_still", 64'(d0), 64'h21);
    step();
    at_neg();
    chk("bp_v2",     {d0, d1, d2},     {32'h24, 32'h25, 32'h26});
    chk("bp_ready3", 64'(io_in_ready), 64'd1);
    chk("bp_count",  64'(io_vecCount), 64'd6);
    idle(1'b0);
    idle(1'b0);

    // Drive the delivered-vector count up to 0xFFFF, then wrap it.
    n = 32'hFFFF - int'(m_vc);
    for (int i = 0; i < n; i++) send(i & 32'hFF, 1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    at_neg();
    chk("cnt_ffff", 64'(io_vecCount), 64'hFFFF);
    send(32'h77, 1'b1);
    idle(1'b0);
    idle(1'b0);
    at_neg();
    chk("cnt_wrap", 64'(io_vecCount), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
